fpu_sched: RTL

- Round-robin scheduler sharing one floating-point unit (the Main FPU, 2-bit process select, stb/ack operand and result handshakes) between NUM_REQ requesters.
- Accepts one request at a time, sequences the FPU's A/B/Z handshakes, and returns the result tagged with the requester ID.
- Sits between client engines and the single FPU instance.

---
 rtl/fpu_sched_pkg.sv | 26 ++
 rtl/fpu_sched_rr_arb.sv | 27 ++
 rtl/fpu_sched.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/fpu_sched_pkg.sv
// rtl/fpu_sched_pkg.sv - shared types, process codes and helpers for the FPU scheduler
package fpu_sched_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SEND_A,
        SEND_B,
        WAIT_Z,
        ACK_Z,
        RESP
    } state_t;

    localparam logic [1:0] PROC_BIN_S = 2'b00;
    localparam logic [1:0] PROC_UN_S  = 2'b01;
    localparam logic [1:0] PROC_BIN_D = 2'b10;
    localparam logic [1:0] PROC_UN_D  = 2'b11;

    function automatic logic is_unary(input logic [1:0] op);
        return (op == PROC_UN_S) || (op == PROC_UN_D);
    endfunction

    function automatic logic is_double(input logic [1:0] op);
        return !((op == PROC_BIN_S) || (op == PROC_UN_S));
    endfunction

endpackage

// File: rtl/fpu_sched_rr_arb.sv
// rtl/fpu_sched_rr_arb.sv - combinational round-robin picker searching from ptr+1 with wrap
module fpu_sched_rr_arb #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    idx,
    output logic               any
);

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        // k = NUM_REQ lands back on ptr itself, so the last winner is considered last
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!any && req[(int'(ptr) + k) % NUM_REQ]) begin
                any = 1'b1;
                grant[(int'(ptr) + k) % NUM_REQ] = 1'b1;
                idx = ID_W'((int'(ptr) + k) % NUM_REQ);
            end
        end
    end

endmodule

// File: rtl/fpu_sched.sv
// rtl/fpu_sched.sv - round-robin sharing of one stb/ack FPU among NUM_REQ requesters
// Optional watchdog abort compiled in with FPU_SCHED_TIMEOUT_EN.
module fpu_sched
    import fpu_sched_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int ID_W           = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [2*NUM_REQ-1:0]  req_op,
    input  logic [64*NUM_REQ-1:0] req_a,
    input  logic [64*NUM_REQ-1:0] req_b,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic                  rsp_valid,
    output logic [ID_W-1:0]       rsp_id,
    output logic [63:0]           rsp_data,
    output logic                  rsp_err,
    input  logic                  rsp_ready,
    output logic [1:0]            fpu_process,
    output logic [31:0]           fpu_as,
    output logic [31:0]           fpu_bs,
    output logic [63:0]           fpu_ad,
    output logic [63:0]           fpu_bd,
    output logic                  fpu_a_stb,
    output logic                  fpu_b_stb,
    input  logic                  fpu_a_ack,
    input  logic                  fpu_b_ack,
    input  logic [31:0]           fpu_zs,
    input  logic [63:0]           fpu_zd,
    input  logic                  fpu_z_stb,
    output logic                  fpu_z_ack
);

    state_t               state_q, state_d;
    logic [ID_W-1:0]      ptr_q, ptr_d;
    logic [ID_W-1:0]      id_q, id_d;
    logic [1:0]           op_q, op_d;
    logic [63:0]          a_q, a_d;
    logic [63:0]          b_q, b_d;
    logic [63:0]          data_q, data_d;
    logic                 a_stb_q, a_stb_d;
    logic                 b_stb_q, b_stb_d;
    logic                 z_ack_q, z_ack_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic [NUM_REQ-1:0]   req_ready_q, req_ready_d;

    logic [NUM_REQ-1:0]   g_onehot;
    logic [ID_W-1:0]      g_idx;
    logic                 g_any;

`ifdef FPU_SCHED_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 err_q, err_d;
`else
    logic                 unused_cfg;
    assign unused_cfg = (TIMEOUT_CYCLES > 0);
`endif

    fpu_sched_rr_arb #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .req   (req_valid),
        .ptr   (ptr_q),
        .grant (g_onehot),
        .idx   (g_idx),
        .any   (g_any)
    );

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        id_d        = id_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        data_d      = data_q;
        a_stb_d     = a_stb_q;
        b_stb_d     = b_stb_q;
        z_ack_d     = z_ack_q;
        rsp_valid_d = rsp_valid_q;
        req_ready_d = '0;
`ifdef FPU_SCHED_TIMEOUT_EN
        err_d       = err_q;
        cnt_d       = cnt_q + 1'b1;
`endif
        case (state_q)
            IDLE: begin
                if (g_any) begin
                    req_ready_d = g_onehot;
                    id_d        = g_idx;
                    ptr_d       = g_idx;
                    op_d        = req_op[2*int'(g_idx) +: 2];
                    a_d         = req_a[64*int'(g_idx) +: 64];
                    b_d         = req_b[64*int'(g_idx) +: 64];
                    a_stb_d     = 1'b1;
                    state_d     = SEND_A;
`ifdef FPU_SCHED_TIMEOUT_EN
                    err_d       = 1'b0;
`endif
                end
            end
            SEND_A: begin
                // strobe drops the cycle after ack; leave only once ack has also fallen
                if (a_stb_q) begin
                    if (fpu_a_ack) a_stb_d = 1'b0;
                end else if (!fpu_a_ack) begin
                    if (is_unary(op_q)) begin
                        state_d = WAIT_Z;
                    end else begin
                        b_stb_d = 1'b1;
                        state_d = SEND_B;
                    end
                end
            end
            SEND_B: begin
                if (b_stb_q) begin
                    if (fpu_b_ack) b_stb_d = 1'b0;
                end else if (!fpu_b_ack) begin
                    state_d = WAIT_Z;
                end
            end
            WAIT_Z: begin
                if (fpu_z_stb) begin
                    data_d  = is_double(op_q) ? fpu_zd : {32'b0, fpu_zs};
                    z_ack_d = 1'b1;
                    state_d = ACK_Z;
                end
            end
            ACK_Z: begin
                if (!fpu_z_stb) begin
                    z_ack_d     = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
`ifdef FPU_SCHED_TIMEOUT_EN
        if (state_q inside {SEND_A, SEND_B, WAIT_Z, ACK_Z}) begin
            if (state_d != state_q) begin
                cnt_d = '0;
            end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                a_stb_d     = 1'b0;
                b_stb_d     = 1'b0;
                z_ack_d     = 1'b0;
                data_d      = '0;
                err_d       = 1'b1;
                rsp_valid_d = 1'b1;
                cnt_d       = '0;
                state_d     = RESP;
            end
        end else begin
            cnt_d = '0;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= ID_W'(NUM_REQ - 1);
            id_q        <= '0;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            data_q      <= '0;
            a_stb_q     <= 1'b0;
            b_stb_q     <= 1'b0;
            z_ack_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            req_ready_q <= '0;
`ifdef FPU_SCHED_TIMEOUT_EN
            cnt_q       <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            id_q        <= id_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            data_q      <= data_d;
            a_stb_q     <= a_stb_d;
            b_stb_q     <= b_stb_d;
            z_ack_q     <= z_ack_d;
            rsp_valid_q <= rsp_valid_d;
            req_ready_q <= req_ready_d;
`ifdef FPU_SCHED_TIMEOUT_EN
            cnt_q       <= cnt_d;
            err_q       <= err_d;
`endif
        end
    end

    assign req_ready   = req_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_id      = id_q;
    assign rsp_data    = data_q;
`ifdef FPU_SCHED_TIMEOUT_EN
    assign rsp_err     = err_q;
`else
    assign rsp_err     = 1'b0;
`endif
    assign fpu_process = op_q;
    assign fpu_as      = a_q[31:0];
    assign fpu_ad      = a_q;
    assign fpu_bs      = b_q[31:0];
    assign fpu_bd      = b_q;
    assign fpu_a_stb   = a_stb_q;
    assign fpu_b_stb   = b_stb_q;
    assign fpu_z_ack   = z_ack_q;

endmodule
